// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin arbiter sharing one bit-serial full adder.
// Operands are added LSB-first, one bit per cycle; the result is published on completion.
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done_id
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             did_q, did_d;

  logic win;
  logic bit_a;
  logic bit_b;
  logic s_bit;
  logic c_nxt;

  // On a tie the requester not served last wins.
  assign win   = (req == 2'b11) ? ~ptr_q : req[1];
  assign bit_a = a_q[cnt_q];
  assign bit_b = b_q[cnt_q];
  assign s_bit = bit_a ^ bit_b ^ c_q;
  assign c_nxt = (bit_a & bit_b) | (bit_a & c_q) | (bit_b & c_q);

  always_comb begin
    state_d = state_q;
    grant_d = 2'b00;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    did_d   = did_q;
    unique case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_d = S_RUN;
          grant_d = win ? 2'b10 : 2'b01;
          ptr_d   = win;
          id_d    = win;
          a_d     = win ? a1 : a0;
          b_d     = win ? b1 : b0;
          res_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        res_d[cnt_q] = s_bit;
        c_d          = c_nxt;
        cnt_d        = cnt_q + CW'(1);
        // Partial sums stay internal; outputs change only here.
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          sum_d   = res_d;
          cout_d  = c_nxt;
          did_d   = id_q;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      did_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      did_q   <= did_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign done_id = did_q;

endmodule

// File: doc/serial_add_arbiter.md
SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  2  per-requester level request; bit i = requester i.
REQ-005 a0, b0  input  WIDTH  requester 0 operands.
REQ-006 a1, b1  input  WIDTH  requester 1 operands.
REQ-007 grant  output  2  one-hot grant pulse, one cycle, marks operand capture.
REQ-008 busy  output  1  high while an addition is in progress (RUN or DONE).
REQ-009 done  output  1  one-cycle pulse; sum/cout/done_id valid.
REQ-010 sum  output  WIDTH  result of the last completed addition.
REQ-011 cout  output  1  carry out of the last completed addition.
REQ-012 done_id  output  1  index of the requester served by the last completed addition.

Function
REQ-013 The block SHALL share a single 1-bit full adder (s = a^b^c, c' = majority(a,b,c)) between the two requesters, processing operands LSB-first, one bit per cycle.
REQ-014 The block SHALL implement states IDLE, RUN, DONE; reset state IDLE.
REQ-015 In IDLE, on an edge where req != 0: pick the winner, capture its operands into shift registers, clear carry and bit counter, set grant[winner]=1 for the following cycle, go to RUN.
REQ-016 Arbitration SHALL be round-robin: if both req bits are high, the requester not served last wins; a single active request always wins; the last-served pointer updates only on a grant.
REQ-017 After reset the last-served pointer SHALL be 1, so requester 0 wins a simultaneous first request.
REQ-018 RUN SHALL last exactly WIDTH cycles, one result bit per cycle; on the edge that computes bit WIDTH-1, go to DONE.
REQ-019 On entry to DONE, sum, cout and done_id SHALL be updated and done=1 for exactly one cycle; the next edge returns to IDLE.
REQ-020 sum/cout/done_id SHALL hold their value until the next DONE entry; no intermediate values are visible on them.
REQ-021 Latency: request sampled at edge k -> grant high in cycle k..k+1 -> done high in cycle k+WIDTH..k+WIDTH+1; the earliest next sampling edge is k+WIDTH+2.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH with cout = bit WIDTH of the full sum (e.g. 0xFF+0x01 -> sum 0x00, cout 1).
REQ-023 req SHALL be ignored in RUN and DONE (not queued); a request still high in IDLE is re-sampled as a new request.
REQ-024 A request dropped before it is sampled in IDLE SHALL NOT be served; operand changes after grant SHALL NOT affect the result.
REQ-025 busy SHALL be 1 in RUN and DONE and 0 in IDLE.

Reset
REQ-026 rst high SHALL immediately force state IDLE and grant=0, busy=0, done=0, sum=0, cout=0, done_id=0, carry=0, counter=0, pointer=1.
REQ-027 Reset mid-operation SHALL abort the addition with no done pulse; the first request after rst falls is handled as after power-up.

Verification
REQ-028 Assert rst for 3 cycles, release -> all outputs 0, state IDLE, no grant while req=00.
REQ-029 req=01, a0=0x5A, b0=0x3C -> grant=01 for one cycle, done 8 cycles after the grant cycle, sum=0x96, cout=0, done_id=0, busy high for 9 cycles.
REQ-030 req=10, a1=0xFF, b1=0x01 -> sum=0x00, cout=1, done_id=1.
REQ-031 req=11 held after reset with distinct operands -> served order 0,1,0,1; each done_id matches; gap of 10 cycles between grants.
REQ-032 req=01 granted, rst pulsed in the 4th RUN cycle -> no done, outputs 0; then req=10, a1=0x12, b1=0x34 -> sum=0x46, done_id=1.
REQ-033 req=10 pulsed for one cycle during RUN of requester 0 and dropped -> requester 1 never granted; only one done pulse.
